decoder_sweep: RTL

Sequential binary-to-one-hot decoder: the inverse direction of the one-hot encoder in the same datapath. It accepts a command `{start index, length}` over a valid/ready handshake. It then emits a burst of one-hot vectors on a valid/ready output stream, with the set bit advancing one position per beat and wrapping modulo `VECT_W`. It sits upstream of the encoder, either to drive one-hot select lines or to feed the encoder for round-trip checks.

---
 rtl/enc_dec_pkg.sv | 11 +
 rtl/bin2onehot.sv | 14 +
 rtl/decoder_sweep.sv | 106 ++++++++++
 3 files changed

// File: rtl/enc_dec_pkg.sv
// Shared definitions for the one-hot encoder/decoder pair: state encoding and
// default geometry.
package enc_dec_pkg;
  localparam int DEF_VECT_W = 8;
  localparam int DEF_BIN_W  = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;
endpackage

// File: rtl/bin2onehot.sv
// Combinational binary to one-hot decode; an index >= VECT_W yields all zeros.
module bin2onehot #(
  parameter int VECT_W = 8,
  parameter int BIN_W  = 3
) (
  input  logic [BIN_W-1:0]  i_bin,
  output logic [VECT_W-1:0] o_vec
);
  always_comb begin
    o_vec = '0;
    for (int i = 0; i < VECT_W; i++)
      if (i_bin == BIN_W'(i)) o_vec[i] = 1'b1;
  end
endmodule

// File: rtl/decoder_sweep.sv
// Command-driven burst of one-hot vectors with a rotating set bit.
// Optional out-of-range start reporting via DECODER_RANGE_CHECK_EN.
module decoder_sweep
  import enc_dec_pkg::*;
#(
  parameter int VECT_W = DEF_VECT_W,
  parameter int BIN_W  = DEF_BIN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BIN_W-1:0]  in_idx,
  input  logic [BIN_W-1:0]  in_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VECT_W-1:0] out_vec,
  output logic              out_last
`ifdef DECODER_RANGE_CHECK_EN
  ,
  output logic              out_err
`endif
);
  // One extra bit so VECT_W == 2**BIN_W is representable.
  localparam logic [BIN_W:0] LP_VW   = (BIN_W+1)'(VECT_W);
  localparam logic [BIN_W:0] LP_LAST = (BIN_W+1)'(VECT_W - 1);

  state_t           r_state, w_state_nxt;
  logic [BIN_W-1:0] r_idx, w_idx_nxt;
  logic [BIN_W-1:0] r_rem, w_rem_nxt;
  logic             w_accept, w_beat, w_oor;
  logic [VECT_W-1:0] w_vec;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_RUN);
  assign w_accept  = in_valid && in_ready;
  assign w_beat    = out_valid && out_ready;
  assign w_oor     = ({1'b0, in_idx} >= LP_VW);

`ifdef DECODER_RANGE_CHECK_EN
  logic r_err, w_err_nxt;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_rem_nxt   = r_rem;
`ifdef DECODER_RANGE_CHECK_EN
    w_err_nxt   = r_err;
`endif
    case (r_state)
      ST_IDLE: if (w_accept) begin
        w_state_nxt = ST_RUN;
        w_idx_nxt   = in_idx;
        w_rem_nxt   = in_len;
`ifdef DECODER_RANGE_CHECK_EN
        // A bad start collapses to a single flagged beat.
        w_err_nxt   = w_oor;
        if (w_oor) w_rem_nxt = '0;
`endif
      end
      ST_RUN: if (w_beat) begin
        if (r_rem == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_idx_nxt = ({1'b0, r_idx} >= LP_LAST) ? '0 : r_idx + BIN_W'(1);
          w_rem_nxt = r_rem - BIN_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_rem   <= '0;
`ifdef DECODER_RANGE_CHECK_EN
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_rem   <= w_rem_nxt;
`ifdef DECODER_RANGE_CHECK_EN
      r_err   <= w_err_nxt;
`endif
    end
  end

  bin2onehot #(.VECT_W(VECT_W), .BIN_W(BIN_W)) u_dec (
    .i_bin (r_idx),
    .o_vec (w_vec)
  );

  // Outputs are gated by RUN so IDLE and reset both present zeros.
  assign out_vec  = out_valid ? w_vec : '0;
  assign out_last = out_valid && (r_rem == '0);
`ifdef DECODER_RANGE_CHECK_EN
  assign out_err  = out_valid && r_err;
`else
  logic w_unused;
  assign w_unused = w_oor;
`endif
endmodule
